// File: rtl/memory_port_arbiter_pkg.sv
// memory_port_arbiter_pkg: shared owner codes, FSM states and owner decode
package memory_port_arbiter_pkg;
   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_I = 2'd1;
   localparam logic [1:0] OWNER_D = 2'd2;
   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_BUSY_I,
      ARB_BUSY_D,
      ARB_DONE_I,
      ARB_DONE_D
   } arb_state_t;
   function automatic logic [1:0] owner_of(arb_state_t s);
      return (s == ARB_BUSY_I || s == ARB_DONE_I) ? OWNER_I :
             (s == ARB_BUSY_D || s == ARB_DONE_D) ? OWNER_D : OWNER_NONE;
   endfunction
endpackage

// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if: cache-side and memory-side signals of the shared port
interface memory_port_arbiter_if;
   logic        l1i_req;
   logic [31:0] l1i_address;
   logic        l1d_req;
   logic        l1d_write;
   logic [31:0] l1d_address;
   logic [31:0] l1d_write_data;
   logic        mem_req;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_ack;
   logic [31:0] mem_read_data;
   logic [31:0] read_data;
   logic        l1i_ready;
   logic        l1d_ready;
   logic        stall_l1i;
   logic        stall_l1d;
   logic [1:0]  owner;
   modport master (
      input  l1i_req, l1i_address, l1d_req, l1d_write, l1d_address, l1d_write_data,
             mem_ack, mem_read_data,
      output mem_req, mem_write, mem_address, mem_write_data, read_data,
             l1i_ready, l1d_ready, stall_l1i, stall_l1d, owner
   );
   modport slave (
      output l1i_req, l1i_address, l1d_req, l1d_write, l1d_address, l1d_write_data,
             mem_ack, mem_read_data,
      input  mem_req, mem_write, mem_address, mem_write_data, read_data,
             l1i_ready, l1d_ready, stall_l1i, stall_l1d, owner
   );
endinterface

// File: rtl/memory_port_arbiter_starve_counter.sv
// arb_starve_counter: saturating count of D grants taken while I waits
module arb_starve_counter #(
   parameter int STARVE_LIMIT = 4,
   parameter int COUNT_WIDTH = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clear,
   output logic at_limit
);
   localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(STARVE_LIMIT);
   logic [COUNT_WIDTH-1:0] count;
   assign at_limit = count == LIMIT;
   always_ff @(posedge clock)
      count <= (reset || clear) ? '0 : (inc && !at_limit) ? count + COUNT_WIDTH'(1) : count;
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: one-at-a-time sharing of the memory port between L1I and L1D
module memory_port_arbiter
   import memory_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int COUNT_WIDTH = 3
) (
   input logic clock,
   input logic reset,
   memory_port_arbiter_if.master bus
);
   arb_state_t state, next_state;
   logic grant_i, grant_d, at_limit, busy;
   always_comb begin
      busy = state == ARB_BUSY_I || state == ARB_BUSY_D;
      grant_i = state == ARB_IDLE && bus.l1i_req && (!bus.l1d_req || at_limit);
      grant_d = state == ARB_IDLE && bus.l1d_req && !grant_i;
      next_state = state;
      case (state)
         ARB_IDLE:   next_state = grant_i ? ARB_BUSY_I : grant_d ? ARB_BUSY_D : ARB_IDLE;
         ARB_BUSY_I: next_state = bus.mem_ack ? ARB_DONE_I : ARB_BUSY_I;
         ARB_BUSY_D: next_state = bus.mem_ack ? ARB_DONE_D : ARB_BUSY_D;
         default:    next_state = ARB_IDLE;
      endcase
   end
   always_ff @(posedge clock)
      state <= reset ? ARB_IDLE : next_state;
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.mem_write <= 1'b0;
         bus.mem_address <= '0;
         bus.mem_write_data <= '0;
         bus.read_data <= '0;
      end else begin
         if (grant_i) begin
            bus.mem_write <= 1'b0;
            bus.mem_address <= bus.l1i_address;
         end
         if (grant_d) begin
            bus.mem_write <= bus.l1d_write;
            bus.mem_address <= bus.l1d_address;
            bus.mem_write_data <= bus.l1d_write_data;
         end
         if (busy && bus.mem_ack) begin
            bus.mem_write <= 1'b0;
            if (!bus.mem_write) bus.read_data <= bus.mem_read_data;
         end
      end
   end
   // an I grant or an uncontested D grant resets the fairness window
   arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT), .COUNT_WIDTH(COUNT_WIDTH)) u_starve (
      .clock(clock),
      .reset(reset),
      .inc(grant_d && bus.l1i_req),
      .clear(grant_i || (grant_d && !bus.l1i_req)),
      .at_limit(at_limit)
   );
   assign bus.mem_req = busy;
   assign bus.l1i_ready = state == ARB_DONE_I;
   assign bus.l1d_ready = state == ARB_DONE_D;
   assign bus.stall_l1i = bus.l1i_req && !bus.l1i_ready;
   assign bus.stall_l1d = bus.l1d_req && !bus.l1d_ready;
   assign bus.owner = owner_of(state);
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed vectors with hand-computed expectations
module tb_memory_port_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   memory_port_arbiter_if bus ();
   memory_port_arbiter #(.STARVE_LIMIT(4), .COUNT_WIDTH(3)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );
   always #5 clock = ~clock;
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   initial begin
      bus.l1i_req = 0; bus.l1i_address = 0;
      bus.l1d_req = 0; bus.l1d_write = 0; bus.l1d_address = 0; bus.l1d_write_data = 0;
      bus.mem_ack = 0; bus.mem_read_data = 0;
      tick(); tick();
      chk("rst_mem_req", {31'd0, bus.mem_req}, 0);
      chk("rst_owner", {30'd0, bus.owner}, 0);
      chk("rst_read_data", bus.read_data, 0);
      chk("rst_addr", bus.mem_address, 0);
      chk("rst_count", {29'd0, dut.u_starve.count}, 0);
      reset = 0;
      tick();
      // single I read, ack after 2 cycles
      bus.l1i_req = 1; bus.l1i_address = 32'h100;
      #1 chk("i_stall_pre", {31'd0, bus.stall_l1i}, 1);
      tick();
      chk("i_mem_req", {31'd0, bus.mem_req}, 1);
      chk("i_addr", bus.mem_address, 32'h100);
      chk("i_write", {31'd0, bus.mem_write}, 0);
      chk("i_owner", {30'd0, bus.owner}, 1);
      tick();
      chk("i_hold", {31'd0, bus.mem_req}, 1);
      bus.mem_ack = 1; bus.mem_read_data = 32'hDEADBEEF;
      tick();
      chk("i_ready", {31'd0, bus.l1i_ready}, 1);
      chk("i_rdata", bus.read_data, 32'hDEADBEEF);
      chk("i_req_drop", {31'd0, bus.mem_req}, 0);
      chk("i_stall_fall", {31'd0, bus.stall_l1i}, 0);
      bus.mem_ack = 0; bus.l1i_req = 0;
      tick();
      chk("i_ready_once", {31'd0, bus.l1i_ready}, 0);
      chk("i_idle_owner", {30'd0, bus.owner}, 0);
      // D write, fields held while inputs change, ack after 3 cycles
      bus.l1d_req = 1; bus.l1d_write = 1; bus.l1d_address = 32'h2004; bus.l1d_write_data = 32'h12345678;
      tick();
      chk("d_write", {31'd0, bus.mem_write}, 1);
      chk("d_owner", {30'd0, bus.owner}, 2);
      bus.l1d_address = 32'hFFFF; bus.l1d_write_data = 0;
      tick();
      chk("d_addr_stable", bus.mem_address, 32'h2004);
      chk("d_wdata_stable", bus.mem_write_data, 32'h12345678);
      tick();
      chk("d_write_stable", {31'd0, bus.mem_write}, 1);
      bus.mem_ack = 1; bus.mem_read_data = 32'h55555555;
      tick();
      chk("d_ready", {31'd0, bus.l1d_ready}, 1);
      chk("d_rdata_kept", bus.read_data, 32'hDEADBEEF);
      chk("d_write_clr", {31'd0, bus.mem_write}, 0);
      bus.mem_ack = 0; bus.l1d_req = 0; bus.l1d_write = 0;
      tick();
      // simultaneous I and D: D first, then I
      bus.l1i_req = 1; bus.l1i_address = 32'h300;
      bus.l1d_req = 1; bus.l1d_address = 32'h400;
      tick();
      chk("sim_owner_d", {30'd0, bus.owner}, 2);
      chk("sim_addr_d", bus.mem_address, 32'h400);
      chk("sim_count1", {29'd0, dut.u_starve.count}, 1);
      bus.mem_ack = 1; bus.mem_read_data = 32'hAAAA0001;
      tick();
      chk("sim_d_ready", {31'd0, bus.l1d_ready}, 1);
      chk("sim_stall_i", {31'd0, bus.stall_l1i}, 1);
      bus.mem_ack = 0; bus.l1d_req = 0;
      tick();
      chk("sim_idle", {30'd0, bus.owner}, 0);
      tick();
      chk("sim_owner_i", {30'd0, bus.owner}, 1);
      chk("sim_addr_i", bus.mem_address, 32'h300);
      chk("sim_count0", {29'd0, dut.u_starve.count}, 0);
      bus.mem_ack = 1; bus.mem_read_data = 32'hBBBB0002;
      tick();
      chk("sim_i_rdata", bus.read_data, 32'hBBBB0002);
      bus.mem_ack = 0; bus.l1i_req = 0;
      tick();
      // starvation: I held, D continuous -> 4 D grants then I
      bus.l1i_req = 1; bus.l1i_address = 32'h500;
      bus.l1d_req = 1; bus.l1d_address = 32'h600;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("starve_owner_d", {30'd0, bus.owner}, 2);
         chk("starve_count", {29'd0, dut.u_starve.count}, k);
         bus.mem_ack = 1; bus.mem_read_data = k;
         tick();
         bus.mem_ack = 0;
         tick();
      end
      tick();
      chk("starve_owner_i", {30'd0, bus.owner}, 1);
      chk("starve_addr_i", bus.mem_address, 32'h500);
      chk("starve_count_clr", {29'd0, dut.u_starve.count}, 0);
      bus.mem_ack = 1; bus.mem_read_data = 32'h5;
      tick();
      chk("starve_i_ready", {31'd0, bus.l1i_ready}, 1);
      bus.mem_ack = 0; bus.l1i_req = 0; bus.l1d_req = 0;
      tick();
      // reset one cycle after a D grant, stale ack afterwards
      bus.l1i_req = 1; bus.l1i_address = 32'h0;
      bus.l1d_req = 1; bus.l1d_write = 1; bus.l1d_address = 32'h700; bus.l1d_write_data = 32'h77;
      tick();
      chk("rb_owner_d", {30'd0, bus.owner}, 2);
      chk("rb_count", {29'd0, dut.u_starve.count}, 1);
      tick();
      reset = 1;
      tick();
      chk("rb_mem_req", {31'd0, bus.mem_req}, 0);
      chk("rb_d_ready", {31'd0, bus.l1d_ready}, 0);
      chk("rb_owner", {30'd0, bus.owner}, 0);
      chk("rb_count_clr", {29'd0, dut.u_starve.count}, 0);
      reset = 0; bus.l1i_req = 0; bus.l1d_req = 0; bus.l1d_write = 0;
      tick();
      bus.mem_ack = 1; bus.mem_read_data = 32'h1234;
      tick();
      chk("rb_stale_ready", {31'd0, bus.l1d_ready}, 0);
      chk("rb_stale_owner", {30'd0, bus.owner}, 0);
      chk("rb_stale_rdata", bus.read_data, 0);
      bus.mem_ack = 0;
      // reset coincident with ack: reset wins
      bus.l1d_req = 1; bus.l1d_address = 32'h800;
      tick();
      chk("ra_owner_d", {30'd0, bus.owner}, 2);
      reset = 1; bus.mem_ack = 1; bus.mem_read_data = 32'h99;
      tick();
      chk("ra_ready", {31'd0, bus.l1d_ready}, 0);
      chk("ra_rdata", bus.read_data, 0);
      chk("ra_mem_req", {31'd0, bus.mem_req}, 0);
      reset = 0; bus.mem_ack = 0; bus.l1d_req = 0;
      tick();
      // spurious ack in IDLE and in DONE_I
      bus.mem_ack = 1; bus.mem_read_data = 32'h1111;
      tick();
      chk("sp_idle_owner", {30'd0, bus.owner}, 0);
      chk("sp_idle_ready", {30'd0, bus.l1i_ready, bus.l1d_ready}, 0);
      chk("sp_idle_rdata", bus.read_data, 0);
      bus.mem_ack = 0;
      bus.l1i_req = 1; bus.l1i_address = 32'h900;
      tick();
      chk("sp_owner_i", {30'd0, bus.owner}, 1);
      bus.mem_ack = 1; bus.mem_read_data = 32'hCAFEF00D;
      tick();
      chk("sp_i_ready", {31'd0, bus.l1i_ready}, 1);
      bus.l1i_req = 0; bus.mem_read_data = 32'h2222;
      tick();
      chk("sp_done_ready", {31'd0, bus.l1i_ready}, 0);
      chk("sp_done_owner", {30'd0, bus.owner}, 0);
      chk("sp_done_rdata", bus.read_data, 32'hCAFEF00D);
      chk("sp_done_req", {31'd0, bus.mem_req}, 0);
      bus.mem_ack = 0;
      tick();
      chk("sp_final_idle", {30'd0, bus.owner}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
